mux_arbiter_2x1: RTL

- Two-requester round-robin arbiter that owns the select of the shared 8-bit 2:1 operand mux and registers the selected byte into a valid/ready output stage.
- Sits between two TinyCPU byte producers (e.g. register-file read port and immediate/ALU feedback) and the single downstream consumer.
- Grants are burst-based, with a bounded burst length so neither requester can starve the other.

---
 rtl/mux_arbiter_2x1.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mux_arbiter_2x1.sv
// Round-robin 2:1 byte arbiter with burst cap and registered valid/ready output.
// Optional per-requester accept counters when ARB_STATS_EN is defined.
module mux_arbiter_2x1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef ARB_STATS_EN
  output logic [15:0]      beats0,
  output logic [15:0]      beats1,
`endif
  input  logic             out_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_sel;
  logic             w_sel_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             w_space;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_acc;
  logic             w_cap;

  assign w_space   = !r_out_valid || out_ready;
  // Acks are suppressed during reset so no byte is lost to a reset edge.
  assign w_ack0    = !reset && (r_state == ST_OWN0) && req0 && w_space;
  assign w_ack1    = !reset && (r_state == ST_OWN1) && req1 && w_space;
  assign w_acc     = w_ack0 || w_ack1;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cap     = w_acc && (w_cnt_inc == CNT_W'(MAX_BEATS));

  assign gnt0      = (r_state == ST_OWN0);
  assign gnt1      = (r_state == ST_OWN1);
  assign ack0      = w_ack0;
  assign ack1      = w_ack1;
  assign sel       = r_sel;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Next-state: arbitration in IDLE, release on req drop or burst cap.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = w_acc ? w_cnt_inc : r_cnt;
    unique case (1'b1)
      (r_state == ST_OWN0): begin
        if (!req0 || w_cap) begin
          w_last_nxt = 1'b0;
          w_cnt_nxt  = '0;
          if (req1)      w_state_nxt = ST_OWN1;
          else if (req0) w_state_nxt = ST_OWN0;
          else           w_state_nxt = ST_IDLE;
        end
      end
      (r_state == ST_OWN1): begin
        if (!req1 || w_cap) begin
          w_last_nxt = 1'b1;
          w_cnt_nxt  = '0;
          if (req0)      w_state_nxt = ST_OWN0;
          else if (req1) w_state_nxt = ST_OWN1;
          else           w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        if (req0 && req1)
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        else if (req0)
          w_state_nxt = ST_OWN0;
        else if (req1)
          w_state_nxt = ST_OWN1;
        else
          w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select follows the owner; it holds its last value while idle.
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_state_nxt == ST_OWN1)
      w_sel_nxt = 1'b1;
    else if (w_state_nxt == ST_OWN0)
      w_sel_nxt = 1'b0;
  end

  // Arbiter state and output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      if (w_acc) begin
        r_out_data  <= w_ack1 ? data1 : data0;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_beats0;
  logic [15:0] r_beats1;

  assign beats0 = r_beats0;
  assign beats1 = r_beats1;

  // Saturating accept counters per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beats0 <= '0;
      r_beats1 <= '0;
    end else begin
      if (w_ack0 && (r_beats0 != 16'hFFFF))
        r_beats0 <= r_beats0 + 16'd1;
      if (w_ack1 && (r_beats1 != 16'hFFFF))
        r_beats1 <= r_beats1 + 16'd1;
    end
  end
`else
  // Accept counters are not built in this configuration.
`endif

endmodule
